// File: rtl/trivium_pkg.sv
// Shared constants, tap positions and FSM state type for the Trivium keystream generator.
package trivium_pkg;

    localparam int unsigned KEY_W   = 80;
    localparam int unsigned IV_W    = 80;
    localparam int unsigned STATE_W = 288;

    // Register boundaries: A = s[287:195], B = s[194:111], C = s[110:0]
    localparam int unsigned A_LO = 195;
    localparam int unsigned B_LO = 111;

    localparam int unsigned T1_A    = 222;
    localparam int unsigned T1_B    = 195;
    localparam int unsigned T1_AND0 = 196;
    localparam int unsigned T1_AND1 = 197;
    localparam int unsigned T1_X    = 117;

    localparam int unsigned T2_A    = 126;
    localparam int unsigned T2_B    = 111;
    localparam int unsigned T2_AND0 = 112;
    localparam int unsigned T2_AND1 = 113;
    localparam int unsigned T2_X    = 24;

    localparam int unsigned T3_A    = 45;
    localparam int unsigned T3_B    = 0;
    localparam int unsigned T3_AND0 = 1;
    localparam int unsigned T3_AND1 = 2;
    localparam int unsigned T3_X    = 219;

    typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

    function automatic logic [STATE_W-1:0] init_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        return {key, 13'b0, iv, 112'b0, 3'b111};
    endfunction

    function automatic bit legal_width(input int unsigned w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32) ||
               (w == 64);
    endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: produces the output bit z and the advanced state.
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] s,
    output logic [STATE_W-1:0] s_next,
    output logic               z
);

    logic t1, t2, t3;
    logic t1_n, t2_n, t3_n;

    assign t1 = s[T1_A] ^ s[T1_B];
    assign t2 = s[T2_A] ^ s[T2_B];
    assign t3 = s[T3_A] ^ s[T3_B];

    assign z = t1 ^ t2 ^ t3;

    assign t1_n = t1 ^ (s[T1_AND0] & s[T1_AND1]) ^ s[T1_X];
    assign t2_n = t2 ^ (s[T2_AND0] & s[T2_AND1]) ^ s[T2_X];
    assign t3_n = t3 ^ (s[T3_AND0] & s[T3_AND1]) ^ s[T3_X];

    // Each register shifts toward bit 0 and takes its feedback at the top.
    assign s_next = {t3_n, s[STATE_W-1:A_LO+1],
                     t1_n, s[A_LO-1:B_LO+1],
                     t2_n, s[B_LO-1:1]};

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator producing W bits per handshake.
// Define TRIVIUM_CIPHER_EN to add pt_data and emit pt_data ^ keystream instead.
module trivium_stream
    import trivium_pkg::*;
#(
    parameter int unsigned W           = 1,
    parameter int unsigned INIT_ROUNDS = 1152
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    output logic             busy,
    output logic             ks_valid,
    input  logic             ks_ready,
`ifdef TRIVIUM_CIPHER_EN
    input  logic [W-1:0]     pt_data,
`endif
    output logic [W-1:0]     ks_data
);

    localparam int unsigned INIT_CYCLES = INIT_ROUNDS / W;
    localparam int unsigned CNT_W       = $clog2(INIT_CYCLES + 1);

    if (!legal_width(W)) begin : g_bad_width
        $error("trivium_stream: W must be one of 1, 2, 4, 8, 16, 32, 64");
    end
    if (INIT_ROUNDS == 0 || (INIT_ROUNDS % W) != 0) begin : g_bad_rounds
        $error("trivium_stream: INIT_ROUNDS must be a nonzero multiple of W");
    end

    state_e             state_q, state_d;
    logic [STATE_W-1:0] s_q, s_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] s_adv;
    logic [W-1:0]       z;

    // W rounds chained per cycle; z[0] comes from the first round.
    for (genvar i = 0; i < W; i++) begin : g_round
        logic [STATE_W-1:0] s_in;
        logic [STATE_W-1:0] s_out;
        if (i == 0) begin : g_first
            assign s_in = s_q;
        end else begin : g_next
            assign s_in = g_round[i-1].s_out;
        end
        trivium_round u_round (
            .s      (s_in),
            .s_next (s_out),
            .z      (z[i])
        );
    end
    assign s_adv = g_round[W-1].s_out;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = StInit;
            s_d     = init_state(key, iv);
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StInit: begin
                    s_d   = s_adv;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (ks_ready) begin
                        s_d = s_adv;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == StInit);
    assign ks_valid = (state_q == StRun);

`ifdef TRIVIUM_CIPHER_EN
    assign ks_data = pt_data ^ z;
`else
    assign ks_data = z;
`endif

endmodule

// File: tb/tb_trivium_stream.sv
// Self-checking bench for trivium_stream at W=1, 8 and 64 against a bit-serial Trivium model.
module tb_trivium_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load;
    logic [79:0] key, iv;
    logic        rdy1, rdy8, rdy64;
    logic        busy1, busy8, busy64;
    logic        val1, val8, val64;
    logic [0:0]  ks1;
    logic [7:0]  ks8;
    logic [63:0] ks64;

    int n_cmp = 0;
    int n_err = 0;

    bit ref_bits [0:1023];
    bit q1[$], q8[$], q64[$];

`ifdef TRIVIUM_CIPHER_EN
    logic [0:0]  pt1  = '0;
    logic [7:0]  pt8  = '0;
    logic [63:0] pt64 = '0;
    logic        busy_d, val_d;
    logic [7:0]  ks_d;
`endif

    trivium_stream #(.W(1), .INIT_ROUNDS(1152)) u_dut1 (
        .clk (clk), .rst (rst), .load (load), .key (key), .iv (iv),
        .busy (busy1), .ks_valid (val1), .ks_ready (rdy1),
`ifdef TRIVIUM_CIPHER_EN
        .pt_data (pt1),
`endif
        .ks_data (ks1)
    );

    trivium_stream #(.W(8), .INIT_ROUNDS(1152)) u_dut8 (
        .clk (clk), .rst (rst), .load (load), .key (key), .iv (iv),
        .busy (busy8), .ks_valid (val8), .ks_ready (rdy8),
`ifdef TRIVIUM_CIPHER_EN
        .pt_data (pt8),
`endif
        .ks_data (ks8)
    );

    trivium_stream #(.W(64), .INIT_ROUNDS(1152)) u_dut64 (
        .clk (clk), .rst (rst), .load (load), .key (key), .iv (iv),
        .busy (busy64), .ks_valid (val64), .ks_ready (rdy64),
`ifdef TRIVIUM_CIPHER_EN
        .pt_data (pt64),
`endif
        .ks_data (ks64)
    );

`ifdef TRIVIUM_CIPHER_EN
    // Decryptor: same key/iv/handshake, fed the ciphertext of u_dut8.
    trivium_stream #(.W(8), .INIT_ROUNDS(1152)) u_dec8 (
        .clk (clk), .rst (rst), .load (load), .key (key), .iv (iv),
        .busy (busy_d), .ks_valid (val_d), .ks_ready (rdy8),
        .pt_data (ks8),
        .ks_data (ks_d)
    );
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bit-serial Trivium in the classic s1..s288 form, split into registers A, B, C
    // (index 0 of each queue is the lowest-numbered cell).
    task automatic model_run(input logic [79:0] k, input logic [79:0] v, input int nbits);
        bit qa[$], qb[$], qc[$];
        bit t1, t2, t3, zz;
        for (int i = 0; i < 93; i++) qa.push_back(i < 80 ? k[79-i] : 1'b0);
        for (int i = 0; i < 84; i++) qb.push_back(i < 80 ? v[79-i] : 1'b0);
        for (int i = 0; i < 111; i++) qc.push_back(i >= 108);
        for (int r = 0; r < 1152 + nbits; r++) begin
            t1 = qa[65] ^ qa[92];
            t2 = qb[68] ^ qb[83];
            t3 = qc[65] ^ qc[110];
            zz = t1 ^ t2 ^ t3;
            t1 = t1 ^ (qa[90] & qa[91]) ^ qb[77];
            t2 = t2 ^ (qb[81] & qb[82]) ^ qc[86];
            t3 = t3 ^ (qc[108] & qc[109]) ^ qa[68];
            void'(qa.pop_back()); qa.push_front(t3);
            void'(qb.pop_back()); qb.push_front(t1);
            void'(qc.pop_back()); qc.push_front(t2);
            if (r >= 1152) ref_bits[r-1152] = zz;
        end
    endtask

    function automatic logic [63:0] pack64(input bit q[$], input int base);
        logic [63:0] r;
        for (int j = 0; j < 64; j++) r[j] = (base + j < q.size()) ? q[base+j] : 1'bx;
        return r;
    endfunction

    function automatic logic [63:0] ref64(input int base);
        logic [63:0] r;
        for (int j = 0; j < 64; j++) r[j] = ref_bits[base+j];
        return r;
    endfunction

    function automatic logic [7:0] ref8(input int w);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = ref_bits[w*8+j];
        return r;
    endfunction

    typedef struct {
        logic rst;
        logic load;
        logic rdy;
        logic exp_busy;
        logic exp_valid;
        logic chk_zero;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int b1, b8, b64, f1, f8, f64, stalls, words, seen;
        logic [79:0] key2, iv2;
        logic [7:0]  got [$];
        logic        prev_stall;
        logic [7:0]  prev_data;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b0; load = 1'b0; rdy1 = 1'b0; rdy8 = 1'b0; rdy64 = 1'b0;
        key = 80'h9719CFC92A9FF688F9AA;
        iv  = 80'hECBB76B09AFF71D0D151;
        @(negedge clk);

        // Reset, idle, rst-over-load priority and mid-INIT reset abort
        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rst; load = vecs[i].load;
            rdy1 = vecs[i].rdy; rdy8 = vecs[i].rdy; rdy64 = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d busy/valid", i),
                  64'({busy1, busy8, busy64, val1, val8, val64}),
                  64'({{3{vecs[i].exp_busy}}, {3{vecs[i].exp_valid}}}));
            if (vecs[i].chk_zero)
                check($sformatf("vec%0d ks_data zero", i), 64'({ks1, ks8, ks64}), 64'd0);
        end

        // Fixed key/iv at three widths, continuous ready
        rst = 1'b1; rdy1 = 1'b1; rdy8 = 1'b1; rdy64 = 1'b1;
        model_run(key, iv, 512);
        q1.delete(); q8.delete(); q64.delete();
        b1 = 0; b8 = 0; b64 = 0; f1 = 0; f8 = 0; f64 = 0;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int idx = 1; idx <= 3000 && (q1.size() < 512 || q8.size() < 512 || q64.size() < 512);
             idx++) begin
            if (busy1) b1++;
            if (busy8) b8++;
            if (busy64) b64++;
            if (val1 && f1 == 0) f1 = idx;
            if (val8 && f8 == 0) f8 = idx;
            if (val64 && f64 == 0) f64 = idx;
            if (val1 && rdy1) q1.push_back(ks1[0]);
            if (val8 && rdy8) for (int j = 0; j < 8; j++) q8.push_back(ks8[j]);
            if (val64 && rdy64) for (int j = 0; j < 64; j++) q64.push_back(ks64[j]);
            @(negedge clk);
        end
        check("w1 busy cycles", 64'(b1), 64'd1152);
        check("w8 busy cycles", 64'(b8), 64'd144);
        check("w64 busy cycles", 64'(b64), 64'd18);
        check("w1 first valid", 64'(f1), 64'd1153);
        check("w8 first valid", 64'(f8), 64'd145);
        check("w64 first valid", 64'(f64), 64'd19);
        for (int c = 0; c < 8; c++) begin
            check($sformatf("w1 bits %0d", c * 64), pack64(q1, c * 64), ref64(c * 64));
            check($sformatf("w8 bits %0d", c * 64), pack64(q8, c * 64), ref64(c * 64));
            check($sformatf("w64 bits %0d", c * 64), pack64(q64, c * 64), ref64(c * 64));
        end

        // W=8 with random back-pressure
        key = {16'($urandom()), $urandom(), $urandom()};
        iv  = {16'($urandom()), $urandom(), $urandom()};
        model_run(key, iv, 512);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int n = 0; n < 300 && !val8; n++) @(negedge clk);
        check("stall run reached", 64'(val8), 64'd1);
        got.delete(); stalls = 0; prev_stall = 1'b0; prev_data = '0;
        for (int n = 0; n < 400 && (got.size() < 30 || stalls < 10); n++) begin
            rdy8 = ($urandom_range(0, 2) != 0);
            if (prev_stall) check($sformatf("stall hold %0d", n), 64'(ks8), 64'(prev_data));
            if (val8 && rdy8) got.push_back(ks8);
            if (val8 && !rdy8) stalls++;
            prev_stall = val8 && !rdy8;
            prev_data  = ks8;
            @(negedge clk);
        end
        check("stall count", 64'(stalls >= 10), 64'd1);
        for (int w = 0; w < got.size(); w++)
            check($sformatf("stall word %0d", w), 64'(got[w]), 64'(ref8(w)));

        // Load during a transfer, then again mid-INIT
        rdy8 = 1'b1;
        key2 = {16'($urandom()), $urandom(), $urandom()};
        iv2  = {16'($urandom()), $urandom(), $urandom()};
        check("pre-load handshake", 64'(val8 && rdy8), 64'd1);
        key = key2; iv = iv2; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load over transfer", 64'({busy8, val8}), 64'b10);
        repeat (50) @(negedge clk);
        key = {16'($urandom()), $urandom(), $urandom()};
        iv  = {16'($urandom()), $urandom(), $urandom()};
        model_run(key, iv, 512);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        b8 = 0; f8 = 0; q8.delete();
        for (int idx = 1; idx <= 400 && q8.size() < 256; idx++) begin
            if (busy8) b8++;
            if (val8 && f8 == 0) f8 = idx;
            if (val8 && rdy8) for (int j = 0; j < 8; j++) q8.push_back(ks8[j]);
            @(negedge clk);
        end
        check("reload busy cycles", 64'(b8), 64'd144);
        check("reload first valid", 64'(f8), 64'd145);
        for (int c = 0; c < 4; c++)
            check($sformatf("reload bits %0d", c * 64), pack64(q8, c * 64), ref64(c * 64));

`ifdef TRIVIUM_CIPHER_EN
        // Encrypt 8'hA5 and decrypt it back with a second instance
        key = {16'($urandom()), $urandom(), $urandom()};
        iv  = {16'($urandom()), $urandom(), $urandom()};
        model_run(key, iv, 512);
        pt8 = 8'hA5;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int n = 0; n < 300 && !val8; n++) @(negedge clk);
        check("cipher run reached", 64'(val8 && val_d), 64'd1);
        seen = 0;
        for (int n = 0; n < 40 && seen < 16; n++) begin
            if (val8 && rdy8) begin
                check($sformatf("cipher word %0d", seen), 64'(ks8), 64'(8'hA5 ^ ref8(seen)));
                check($sformatf("decrypt word %0d", seen), 64'(ks_d), 64'h00000000000000A5);
                seen++;
            end
            @(negedge clk);
        end
        check("cipher words seen", 64'(seen), 64'd16);
`endif
        words = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
